// File: rtl/cfu_tile_driver_if.sv
// cfu_tile_driver_if
//   Groups the four streams around the CFU tile driver.
//   src_* : A/B word pairs from the tile-fetch DMA (driver consumes)
//   res_* : C lane results (driver produces, res_last marks the tile's final lane)
//   cmd_* : CFU command channel (driver initiates)
//   rsp_* : CFU response channel (driver consumes)
//   Modports: master = driver side, slave = environment side.
interface cfu_tile_driver_if;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        input  src_valid, src_a, src_b, res_ready, cmd_ready, rsp_valid,
               rsp_payload_outputs_0,
        output src_ready, res_valid, res_data, res_last, cmd_valid, cmd_payload_function_id,
               cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready
    );

    modport slave (
        output src_valid, src_a, src_b, res_ready, cmd_ready, rsp_valid,
               rsp_payload_outputs_0,
        input  src_ready, res_valid, res_data, res_last, cmd_valid, cmd_payload_function_id,
               cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready
    );
endinterface

// File: rtl/cfu_tile_driver.sv
// cfu_tile_driver
//   Hardware command source for one TPU tile behind the CFU. Streams DEPTH A/B pairs into the
//   CFU buffers, issues the TPU start command with the captured input offset, then reads back
//   every 32-bit lane (4 per row) of every C row and emits them on the result stream.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start          one-cycle tile start pulse (ignored while busy or while done is high)
//     input_offset   9-bit offset captured at start, sent with the start command
//     busy           high from start acceptance until the tile completes
//     done           one-cycle pulse when the last result is consumed
//     error          one-cycle pulse on watchdog abort (constant 0 without the watchdog)
//     bus            src/res/cmd/rsp streams (cfu_tile_driver_if.master)
//   Optional feature: define CFU_DRV_TIMEOUT_EN to build the response watchdog (TIMEOUT cycles).
module cfu_tile_driver #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TPU_SEL = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [8:0]               input_offset,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    cfu_tile_driver_if.master        bus
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [6:0] OpLoad  = 7'(0 + TPU_SEL);
    localparam logic [6:0] OpStart = 7'(2 + TPU_SEL);
    localparam logic [6:0] OpRead  = 7'(4 + TPU_SEL);
    localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadIssue,
        StLoadWait,
        StStartIssue,
        StStartWait,
        StReadIssue,
        StReadWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [8:0]        offset_q, offset_d;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [CntW-1:0]   row_q, row_d;
    logic [1:0]        lane_q, lane_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [9:0]        fid_q, fid_d;
    logic [31:0]       in0_q, in0_d;
    logic [31:0]       in1_q, in1_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              res_last_q, res_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              src_rdy, rsp_rdy;
    logic              last_read;

`ifdef CFU_DRV_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           error_q, error_d;
    logic           in_wait, wd_expire;

    assign in_wait   = (state_q == StLoadWait) || (state_q == StStartWait) ||
                       (state_q == StReadWait);
    assign wd_expire = in_wait && !bus.rsp_valid && (wd_cnt_q == WdW'(TIMEOUT - 1));
    assign error     = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign error          = 1'b0;
`endif

    assign last_read = (row_q == LastIdx) && (lane_q == 2'd3);

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        word_cnt_d  = word_cnt_q;
        row_d       = row_q;
        lane_d      = lane_q;
        cmd_valid_d = cmd_valid_q;
        fid_d       = fid_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        src_rdy     = 1'b0;
        rsp_rdy     = 1'b0;

        if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // done_q gate drops a start that coincides with the done pulse
                if (start && !done_q) begin
                    state_d    = StLoadIssue;
                    offset_d   = input_offset;
                    word_cnt_d = '0;
                    row_d      = '0;
                    lane_d     = '0;
                    busy_d     = 1'b1;
                end
            end
            StLoadIssue: begin
                src_rdy = 1'b1;
                if (bus.src_valid) begin
                    cmd_valid_d = 1'b1;
                    fid_d       = {OpLoad, 3'b000};
                    in0_d       = bus.src_a;
                    in1_d       = bus.src_b;
                    state_d     = StLoadWait;
                end
            end
            StLoadWait: begin
                // Response is only accepted once the command has gone out
                rsp_rdy = !cmd_valid_q;
                if (rsp_rdy && bus.rsp_valid) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = (word_cnt_q == LastIdx) ? StStartIssue : StLoadIssue;
                end
            end
            StStartIssue: begin
                cmd_valid_d = 1'b1;
                fid_d       = {OpStart, 3'b000};
                in0_d       = {23'b0, offset_q};
                in1_d       = '0;
                state_d     = StStartWait;
            end
            StStartWait: begin
                rsp_rdy = !cmd_valid_q;
                if (rsp_rdy && bus.rsp_valid) begin
                    state_d = StReadIssue;
                end
            end
            StReadIssue: begin
                cmd_valid_d = 1'b1;
                fid_d       = {OpRead, 3'b000};
                in0_d       = 32'(row_q);
                in1_d       = 32'(lane_q);
                state_d     = StReadWait;
            end
            StReadWait: begin
                // A still-held result blocks the next response, never the next command
                rsp_rdy = !cmd_valid_q && !res_valid_q;
                if (rsp_rdy && bus.rsp_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = bus.rsp_payload_outputs_0;
                    res_last_d  = last_read;
                    lane_d      = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        row_d = row_q + 1'b1;
                    end
                    state_d = last_read ? StDone : StReadIssue;
                end
            end
            StDone: begin
                if (res_valid_q && bus.res_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef CFU_DRV_TIMEOUT_EN
        error_d = 1'b0;
        if (wd_expire) begin
            state_d     = StIdle;
            cmd_valid_d = 1'b0;
            busy_d      = 1'b0;
            error_d     = 1'b1;
        end
        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (in_wait && !bus.rsp_valid) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            offset_q    <= '0;
            word_cnt_q  <= '0;
            row_q       <= '0;
            lane_q      <= '0;
            cmd_valid_q <= 1'b0;
            fid_q       <= '0;
            in0_q       <= '0;
            in1_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            word_cnt_q  <= word_cnt_d;
            row_q       <= row_d;
            lane_q      <= lane_d;
            cmd_valid_q <= cmd_valid_d;
            fid_q       <= fid_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef CFU_DRV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end
`endif

    assign busy                        = busy_q;
    assign done                        = done_q;
    assign bus.src_ready               = src_rdy;
    assign bus.rsp_ready               = rsp_rdy;
    assign bus.cmd_valid               = cmd_valid_q;
    assign bus.cmd_payload_function_id = fid_q;
    assign bus.cmd_payload_inputs_0    = in0_q;
    assign bus.cmd_payload_inputs_1    = in1_q;
    assign bus.res_valid               = res_valid_q;
    assign bus.res_data                = res_data_q;
    assign bus.res_last                = res_last_q;
endmodule

// File: tb/tb_cfu_tile_driver.sv
// tb_cfu_tile_driver
//   Directed bench for cfu_tile_driver: two instances (TPU_SEL 0 and 1) share one CFU/source/sink
//   model selected by `sel`. The model logs every accepted command and result; each tile's logs
//   are compared against hand-built expected sequences.
module tb_cfu_tile_driver;
    localparam int unsigned Depth    = 16;
    localparam int unsigned NumReads = 4 * Depth;
    localparam int unsigned NumCmds  = Depth + 1 + NumReads;
    localparam int          MaxWait  = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [8:0] input_offset = '0;
    logic       start0, start1, busy0, busy1, done0, done1, error0, error1;

    always #5 clk = ~clk;

    cfu_tile_driver_if bus0 ();
    cfu_tile_driver_if bus1 ();

    assign start0 = start && !sel;
    assign start1 = start && sel;

    cfu_tile_driver #(.DEPTH(Depth), .TPU_SEL(0), .TIMEOUT(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .input_offset(input_offset),
        .busy(busy0), .done(done0), .error(error0), .bus(bus0)
    );
    cfu_tile_driver #(.DEPTH(Depth), .TPU_SEL(1), .TIMEOUT(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .input_offset(input_offset),
        .busy(busy1), .done(done1), .error(error1), .bus(bus1)
    );

    // Model-driven inputs, fanned out to both instances
    logic        m_src_valid = 1'b0, m_res_ready = 1'b0, m_cmd_ready = 1'b0, m_rsp_valid = 1'b0;
    logic [31:0] m_src_a = '0, m_src_b = '0, m_rsp_data = '0;

    assign bus0.src_valid = m_src_valid;
    assign bus0.src_a = m_src_a;
    assign bus0.src_b = m_src_b;
    assign bus0.res_ready = m_res_ready;
    assign bus0.cmd_ready = m_cmd_ready;
    assign bus0.rsp_valid = m_rsp_valid;
    assign bus0.rsp_payload_outputs_0 = m_rsp_data;
    assign bus1.src_valid = m_src_valid;
    assign bus1.src_a = m_src_a;
    assign bus1.src_b = m_src_b;
    assign bus1.res_ready = m_res_ready;
    assign bus1.cmd_ready = m_cmd_ready;
    assign bus1.rsp_valid = m_rsp_valid;
    assign bus1.rsp_payload_outputs_0 = m_rsp_data;

    // Outputs of the selected instance
    logic        o_src_ready, o_res_valid, o_res_last, o_cmd_valid, o_rsp_ready;
    logic        o_busy, o_done, o_error;
    logic [31:0] o_res_data;
    logic [73:0] o_cmd;

    assign o_src_ready = sel ? bus1.src_ready : bus0.src_ready;
    assign o_res_valid = sel ? bus1.res_valid : bus0.res_valid;
    assign o_res_last  = sel ? bus1.res_last : bus0.res_last;
    assign o_res_data  = sel ? bus1.res_data : bus0.res_data;
    assign o_cmd_valid = sel ? bus1.cmd_valid : bus0.cmd_valid;
    assign o_rsp_ready = sel ? bus1.rsp_ready : bus0.rsp_ready;
    assign o_busy      = sel ? busy1 : busy0;
    assign o_done      = sel ? done1 : done0;
    assign o_error     = sel ? error1 : error0;
    assign o_cmd = sel ?
        {bus1.cmd_payload_function_id, bus1.cmd_payload_inputs_0, bus1.cmd_payload_inputs_1} :
        {bus0.cmd_payload_function_id, bus0.cmd_payload_inputs_0, bus0.cmd_payload_inputs_1};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model state
    bit          stall = 1'b0;
    bit          no_start_rsp = 1'b0;
    int          src_idx = 0, cyc = 0, done_cnt = 0, err_cnt = 0;
    int          start_acc_cyc = 0, error_cyc = 0;
    logic        err_busy = 1'b0;
    logic        rsp_acc = 1'b0, hold_prev = 1'b0;
    logic [73:0] cmd_prev = '0;
    logic [31:0] rsp_q[$];
    logic [73:0] cmd_log[$];
    logic [32:0] res_log[$];

    // Everything is decided at the negedge; handshakes complete at the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_rsp_valid = 1'b0;
                m_src_valid = 1'b0;
                rsp_q.delete();
                rsp_acc = 1'b0;
                hold_prev = 1'b0;
            end else begin
                if (rsp_acc) m_rsp_valid = 1'b0;
                if (!m_rsp_valid && rsp_q.size() != 0 &&
                    (!stall || $urandom_range(0, 1) == 0)) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = rsp_q.pop_front();
                end
                rsp_acc = m_rsp_valid && o_rsp_ready;

                if (hold_prev) check("cmd_hold", 128'({o_cmd_valid, o_cmd}), 128'({1'b1, cmd_prev}));
                m_cmd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                hold_prev   = o_cmd_valid && !m_cmd_ready;
                cmd_prev    = o_cmd;
                if (o_cmd_valid && m_cmd_ready) begin
                    cmd_log.push_back(o_cmd);
                    if (o_cmd[73:68] == 6'd1 && no_start_rsp) start_acc_cyc = cyc;
                    else if (o_cmd[73:68] == 6'd2)
                        rsp_q.push_back(32'hC000_0000 | (o_cmd[63:32] << 8) | o_cmd[31:0]);
                    else rsp_q.push_back(32'hDEAD_BEEF);
                end

                m_src_valid = (src_idx < int'(Depth)) && (!stall || $urandom_range(0, 1) == 0);
                m_src_a = 32'(src_idx);
                m_src_b = 32'h100 + 32'(src_idx);
                if (m_src_valid && o_src_ready) src_idx++;

                m_res_ready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
                if (o_res_valid && !m_res_ready) check("rsp_gate", 128'(o_rsp_ready), 128'(0));
                if (o_res_valid && m_res_ready) res_log.push_back({o_res_last, o_res_data});
            end
            if (o_done) done_cnt++;
            if (o_error) begin
                err_cnt++;
                error_cyc = cyc;
                err_busy = o_busy;
            end
        end
    end

    function automatic logic [73:0] exp_cmd(input int i, input logic [8:0] off, input logic s);
        logic [6:0]  op;
        logic [31:0] a, b;
        if (i < int'(Depth)) begin
            op = 7'd0; a = 32'(i); b = 32'h100 + 32'(i);
        end else if (i == int'(Depth)) begin
            op = 7'd2; a = {23'b0, off}; b = '0;
        end else begin
            op = 7'd4; a = 32'((i - int'(Depth) - 1) / 4); b = 32'((i - int'(Depth) - 1) % 4);
        end
        op = op + {6'd0, s};
        return {op, 3'b000, a, b};
    endfunction

    function automatic logic [32:0] exp_res(input int j);
        logic [31:0] row, lane;
        row  = 32'(j / 4);
        lane = 32'(j % 4);
        return {(j == int'(NumReads) - 1), 32'hC000_0000 | (row << 8) | lane};
    endfunction

    task automatic pulse_start(input logic [8:0] off);
        @(negedge clk);
        input_offset = off;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_tile(input string name, input logic [8:0] off, input int extra_starts,
                            input bit start_at_done);
        int t;
        cmd_log.delete();
        res_log.delete();
        done_cnt = 0;
        src_idx = 0;
        pulse_start(off);
        check({name, ":busy"}, 128'(o_busy), 128'(1));
        check({name, ":src_ready"}, 128'(o_src_ready), 128'(1));
        for (int k = 0; k < extra_starts; k++) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (!o_done && t < MaxWait) begin
            @(negedge clk);
            t++;
        end
        check({name, ":done_seen"}, 128'(o_done), 128'(1));
        if (start_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (8) @(negedge clk);
        check({name, ":done_count"}, 128'(done_cnt), 128'(1));
        check({name, ":busy_end"}, 128'(o_busy), 128'(0));
        check({name, ":cmd_count"}, 128'(cmd_log.size()), 128'(NumCmds));
        check({name, ":res_count"}, 128'(res_log.size()), 128'(NumReads));
        for (int i = 0; i < cmd_log.size() && i < int'(NumCmds); i++)
            check({name, ":cmd"}, 128'(cmd_log[i]), 128'(exp_cmd(i, off, sel)));
        for (int j = 0; j < res_log.size() && j < int'(NumReads); j++)
            check({name, ":res"}, 128'(res_log[j]), 128'(exp_res(j)));
    endtask

    initial begin
        int t;
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", 128'({o_busy, o_done, o_error, o_src_ready, o_res_valid,
                                      o_res_last, o_res_data, o_cmd_valid, o_cmd, o_rsp_ready}),
              128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        sel = 1'b0;
        run_tile("basic_sel0", 9'h080, 0, 1'b0);

        sel = 1'b1;
        run_tile("basic_sel1", 9'h1A5, 0, 1'b0);

        sel = 1'b0;
        stall = 1'b1;
        run_tile("backpressure", 9'h033, 0, 1'b0);
        stall = 1'b0;

        run_tile("start_busy", 9'h0C4, 3, 1'b1);

        // Reset while the read of row 5 is outstanding
        cmd_log.delete();
        src_idx = 0;
        pulse_start(9'h055);
        t = 0;
        while (cmd_log.size() <= int'(Depth) + 21 && t < MaxWait) begin
            @(negedge clk);
            t++;
        end
        check("mid_rst:row5", 128'(o_cmd[63:32]), 128'(5));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst:outputs", 128'({o_busy, o_done, o_error, o_src_ready, o_res_valid,
                                        o_res_last, o_res_data, o_cmd_valid, o_cmd, o_rsp_ready}),
              128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_tile("after_rst", 9'h0FF, 0, 1'b0);

`ifdef CFU_DRV_TIMEOUT_EN
        no_start_rsp = 1'b1;
        err_cnt = 0;
        done_cnt = 0;
        src_idx = 0;
        start_acc_cyc = -1000;
        pulse_start(9'h011);
        t = 0;
        while (err_cnt == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("wd:error_seen", 128'(err_cnt), 128'(1));
        check("wd:latency", 128'(error_cyc - start_acc_cyc), 128'(32));
        check("wd:busy", 128'(err_busy), 128'(0));
        repeat (10) @(negedge clk);
        check("wd:single_pulse", 128'(err_cnt), 128'(1));
        check("wd:no_done", 128'(done_cnt), 128'(0));
        check("wd:cmd_valid", 128'(o_cmd_valid), 128'(0));
        no_start_rsp = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`else
        check("no_error_pulses", 128'(err_cnt), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cfu_tile_driver.md
# cfu_tile_driver

Hardware initiator for the CFU command/response interface. It replaces the CPU as the command source for one TPU tile. It streams DEPTH A/B word pairs into the CFU buffers and issues the TPU start command with an input offset. It then reads back every 32-bit lane of every C row and emits the results on a valid/ready result stream. It sits between a tile-fetch DMA (source stream) and the CFU (cmd/rsp ports), allowing tile processing without per-word CPU instructions.

## Interface
- DEPTH, 16: A/B words loaded per tile, and C rows read back (power of two, 2..64)
- TPU_SEL, 0: target TPU; 0 uses ops 0/2/4, 1 uses ops 1/3/5
- TIMEOUT, 1024: response watchdog limit in cycles (used only with CFU_DRV_TIMEOUT_EN)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a tile; ignored while busy
- input_offset  in  9  captured at start; sent with the start command
- busy  out  1  high from start acceptance through done
- done  out  1  one-cycle pulse when the tile completes
- error  out  1  one-cycle pulse on watchdog abort (constant 0 without the macro)
- src_valid / src_ready  in / out  1  A/B pair handshake
- src_a, src_b  in  32  A word and B word
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  32  C lane value
- res_last  out  1  marks the final result of the tile
- cmd_valid / cmd_ready  out / in  1  CFU command handshake
- cmd_payload_function_id  out  10  {op[6:0], 3'b000}
- cmd_payload_inputs_0, cmd_payload_inputs_1  out  32  command operands
- rsp_valid / rsp_ready  in / out  1  CFU response handshake
- rsp_payload_outputs_0  in  32  response data

## Operation
- FSM states: IDLE, LOAD_ISSUE, LOAD_WAIT, START_ISSUE, START_WAIT, READ_ISSUE, READ_WAIT, DONE.
- IDLE: on start, latch input_offset, clear counters, and go to LOAD_ISSUE.
- LOAD_ISSUE: assert src_ready. On src handshake, register cmd op = 0+TPU_SEL with inputs_0 = src_a and inputs_1 = src_b, then go to LOAD_WAIT.
- LOAD_WAIT:
  - Hold cmd_valid until cmd_ready, with payload stable.
  - Then hold rsp_ready = 1 and wait for rsp_valid; rsp data is discarded.
  - Then increment word_cnt. Return to LOAD_ISSUE, or go to START_ISSUE after DEPTH words.
- START_ISSUE → START_WAIT: op = 2+TPU_SEL, inputs_0 = {23'b0, input_offset}, inputs_1 = 0. Wait for the response, which arrives only once the TPU has accepted the start.
- READ_ISSUE: op = 4+TPU_SEL, inputs_0 = row, inputs_1 = lane.
  - Order is row-major: row 0..DEPTH-1, lane 0..3.
  - The CFU stalls its response while the TPU is busy; the driver simply waits.
- READ_WAIT:
  - rsp_ready = ~res_valid. On the rsp handshake, load res_data and set res_valid.
  - res_last = (row == DEPTH-1 && lane == 3).
  - res_valid clears on res_ready.
  - The next read command may be issued while a result is still held.
- DONE: when the last result is consumed, pulse done, deassert busy, and return to IDLE.
- Only one command is outstanding at any time. cmd_valid never deasserts before cmd_ready.
- Read commands also rewind the CFU write pointer, so every tile must include the full read phase. An aborted tile requires a CFU reset before reuse.
- Counters: word_cnt and row are $clog2(DEPTH)+1 bits; lane is 2 bits and wraps 3→0 with row+1.

## Timing
- Reset values: all outputs are 0. This includes cmd payloads, res_data, busy, done and error.
- Reset mid-tile: all state clears immediately and cmd_valid drops. The CFU shares the reset tree, so no protocol recovery is needed.
- start to first src_ready: 1 cycle. src handshake to cmd_valid: 1 cycle.
- Response to the next command: 1 cycle, giving ≥3 cycles per command with a zero-latency CFU.
- rsp accept to res_valid: 1 cycle.
- A start pulse coincident with done is ignored.
- When src_valid is low, the driver waits in LOAD_ISSUE indefinitely.

## Configuration
- CFU_DRV_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in *_WAIT states with no rsp_valid.
  - On reaching TIMEOUT it drops cmd_valid, pulses error, clears busy without pulsing done, and returns to IDLE.
  - The counter resets on every state change.
- CFU_DRV_TIMEOUT_EN undefined: no watchdog logic is built, error is tied 0, and waits are unbounded.

## Test plan
- Basic tile, TPU_SEL=0, DEPTH=16, responding CFU model, src_a = i, src_b = 0x100+i:
  - Expect 16 cmds with function_id 0x000 and inputs matching the sources, then function_id 0x010 with inputs_0 = offset 0x080.
  - Then 64 reads with function_id 0x020, rows 0..15 and lanes 0..3; res_last only on the 64th; one done pulse.
- TPU_SEL=1: function_ids are 0x008/0x018/0x028 only.
- Backpressure: random cmd_ready, src_valid and res_ready stalls.
  - Payload stays stable while cmd_valid && !cmd_ready.
  - No result is dropped or duplicated.
  - rsp_ready is low while res_valid && !res_ready.
- Start pulse while busy: ignored; exactly one tile's worth of commands is issued.
- rst_n low during READ_WAIT at row 5: outputs go to 0 asynchronously; a new start runs a full, correct tile.
- With CFU_DRV_TIMEOUT_EN and TIMEOUT=32, model never responds to the start command: error pulses 32 cycles after cmd accept, busy falls, done is never asserted.
